// File: rtl/framebuffer_loader_pkg.sv
// Shared frame-buffer definitions: loader state encoding, default command byte,
// and the geometry of the dual-port frame memory seen by loader and display reader.
package framebuffer_loader_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'h46;

  localparam int FB_WR_ADDR_W = 12;
  localparam int FB_WR_DATA_W = 8;
  localparam int FB_WR_DEPTH  = 1 << FB_WR_ADDR_W;
  localparam int FB_RD_ADDR_W = 11;
  localparam int FB_RD_DATA_W = 16;
  localparam int FB_RD_DEPTH  = 1 << FB_RD_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_LEN_LO  = 3'd4,
    ST_DATA    = 3'd5,
    ST_DONE    = 3'd6
  } fb_state_e;

endpackage

// File: rtl/framebuffer_loader_header_parser.sv
// Walks the five-byte frame header (IDLE..LEN_LO) and hands start address and
// clamped length to the data stage with a combinational start strobe.
module framebuffer_loader_header_parser
  import framebuffer_loader_pkg::*;
#(
  parameter logic [7:0] HEADER     = DEFAULT_HEADER,
  parameter int         ADDR_WIDTH = FB_WR_ADDR_W
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_xfer,
  input  logic [7:0]            i_byte,
  input  logic                  i_hold,
  input  logic                  i_abort,
  output logic                  o_start,
  output logic [ADDR_WIDTH-1:0] o_start_addr,
  output logic [ADDR_WIDTH:0]   o_length,
  output logic                  o_bad_hdr,
  output logic                  o_busy
);

  // Only the header bits that survive truncation are stored (needs 9 <= ADDR_WIDTH <= 15).
  localparam int HI_ADDR_W = ADDR_WIDTH - 8;
  localparam int HI_LEN_W  = ADDR_WIDTH - 7;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  fb_state_e              r_state;
  logic [HI_ADDR_W-1:0]   r_addr_hi;
  logic [7:0]             r_addr_lo;
  logic [HI_LEN_W-1:0]    r_len_hi;
  logic                   w_take;
  logic [ADDR_WIDTH:0]    w_len_raw;

  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] raw);
    logic [ADDR_WIDTH:0] res;
    if (raw == '0 || raw > LP_DEPTH) res = LP_DEPTH;
    else                             res = raw;
    return res;
  endfunction

  assign w_take       = i_xfer & ~i_hold;
  assign w_len_raw    = {r_len_hi, i_byte};
  assign o_start      = w_take & ~i_abort & (r_state == ST_LEN_LO);
  assign o_start_addr = {r_addr_hi, r_addr_lo};
  assign o_length     = clamp_len(w_len_raw);
  assign o_bad_hdr    = w_take & ~i_abort & (r_state == ST_IDLE) & (i_byte != HEADER);
  assign o_busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_addr_hi <= '0;
      r_addr_lo <= '0;
      r_len_hi  <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
    end else if (w_take) begin
      case (r_state)
        ST_IDLE:    if (i_byte == HEADER) r_state <= ST_ADDR_HI;
        ST_ADDR_HI: begin
          r_addr_hi <= i_byte[HI_ADDR_W-1:0];
          r_state   <= ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          r_addr_lo <= i_byte;
          r_state   <= ST_LEN_HI;
        end
        ST_LEN_HI: begin
          r_len_hi <= i_byte[HI_LEN_W-1:0];
          r_state  <= ST_LEN_LO;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_loader.sv
// Frame-buffer byte loader: parses framed load commands and issues one registered
// write per data byte at wrapping sequential addresses, with done pulse and error count.
module framebuffer_loader
  import framebuffer_loader_pkg::*;
#(
  parameter logic [7:0] HEADER     = DEFAULT_HEADER,
  parameter int         ADDR_WIDTH = FB_WR_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FB_WR_DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    abort,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [FB_WR_DATA_W-1:0] ram_data,
  output logic                    ram_wr,
  output logic                    ram_clk_en,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              err_count
);

  fb_state_e               r_state;
  logic                    r_run;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [ADDR_WIDTH:0]     r_remain;
  logic [ADDR_WIDTH-1:0]   r_ram_addr_p1;
  logic [FB_WR_DATA_W-1:0] r_ram_data_p1;
  logic                    r_ram_wr_p1;
  logic                    r_frame_done_p1;
  logic [7:0]              r_err_count;

  logic                    w_xfer;
  logic                    w_start;
  logic [ADDR_WIDTH-1:0]   w_start_addr;
  logic [ADDR_WIDTH:0]     w_length;
  logic                    w_bad_hdr;
  logic                    w_parser_busy;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_ready   = r_run & (r_state != ST_DONE);
  assign w_xfer     = in_valid & in_ready;
  assign busy       = w_parser_busy | (r_state != ST_IDLE);
  assign ram_clk_en = r_run;
  assign ram_addr   = r_ram_addr_p1;
  assign ram_data   = r_ram_data_p1;
  assign ram_wr     = r_ram_wr_p1;
  assign frame_done = r_frame_done_p1;
  assign err_count  = r_err_count;

  framebuffer_loader_header_parser #(
    .HEADER     (HEADER),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_header_parser (
    .clk          (clk),
    .i_rst_n      (reset),
    .i_xfer       (w_xfer),
    .i_byte       (in_data),
    .i_hold       (r_state != ST_IDLE),
    .i_abort      (abort),
    .o_start      (w_start),
    .o_start_addr (w_start_addr),
    .o_length     (w_length),
    .o_bad_hdr    (w_bad_hdr),
    .o_busy       (w_parser_busy)
  );

  // p0 -> p1: accepted data byte becomes a memory write strike in the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_run           <= 1'b0;
      r_ptr           <= '0;
      r_remain        <= '0;
      r_ram_addr_p1   <= '0;
      r_ram_data_p1   <= '0;
      r_ram_wr_p1     <= 1'b0;
      r_frame_done_p1 <= 1'b0;
      r_err_count     <= '0;
    end else begin
      r_run           <= 1'b1;
      r_ram_wr_p1     <= 1'b0;
      r_frame_done_p1 <= 1'b0;
      if (w_bad_hdr) r_err_count <= sat_inc(r_err_count);
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ptr    <= w_start_addr;
            r_remain <= w_length;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_ram_addr_p1 <= r_ptr;
            r_ram_data_p1 <= in_data;
            r_ram_wr_p1   <= 1'b1;
            r_ptr         <= r_ptr + ADDR_WIDTH'(1);
            r_remain      <= r_remain - (ADDR_WIDTH+1)'(1);
            if (r_remain == (ADDR_WIDTH+1)'(1)) begin
              r_state         <= ST_DONE;
              r_frame_done_p1 <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_loader.sv
// Scoreboard bench for framebuffer_loader: directed frames push expected writes,
// a negedge monitor pops and compares every write strike.
module tb_framebuffer_loader;

  typedef struct packed {
    logic        done;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wr;
  logic        ram_clk_en;
  logic        busy;
  logic        frame_done;
  logic [7:0]  err_count;

  exp_t        exp_q[$];
  logic [7:0]  data_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cyc = -1;
  int          hdr;
  logic        chk_busy_next = 1'b0;

  framebuffer_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wr     (ram_wr),
    .ram_clk_en (ram_clk_en),
    .busy       (busy),
    .frame_done (frame_done),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int eff_len(input logic [15:0] len);
    logic [12:0] t;
    t = len[12:0];
    if (t == 13'd0 || t > 13'd4096) return 4096;
    return int'(t);
  endfunction

  function automatic int pick_gap(input int max_gap);
    if (max_gap > 0) return int'($urandom_range(max_gap, 0));
    return 0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (chk_busy_next) begin
        chk_busy_next = 1'b0;
        check("busy_after_done", busy, 0);
      end
      if (ram_wr) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_data);
        end else begin
          e = exp_q.pop_front();
          check("write_done_addr_data", {frame_done, ram_addr, ram_data}, e);
          if (e.done) begin
            done_cyc = cyc;
            check("ready_low_in_done", in_ready, 0);
            chk_busy_next = 1'b1;
          end
        end
      end else if (frame_done) begin
        n_chk++;
        n_err++;
        $display("FAIL stray_frame_done: got frame_done=1 without write, required 0");
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL handshake_timeout: in_ready=0 for %0d cycles, required 1", n);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_prefix(input logic [15:0] addr, input logic [15:0] len,
                             input int max_gap, output int hdr_cyc);
    send_byte(8'h46, pick_gap(max_gap));
    hdr_cyc = cyc;
    send_byte(addr[15:8], pick_gap(max_gap));
    send_byte(addr[7:0], pick_gap(max_gap));
    send_byte(len[15:8], pick_gap(max_gap));
    send_byte(len[7:0], pick_gap(max_gap));
  endtask

  task automatic send_frame(input logic [15:0] addr, input logic [15:0] len,
                            input int max_gap, output int hdr_cyc);
    int   n;
    exp_t e;
    n = eff_len(len);
    send_prefix(addr, len, max_gap, hdr_cyc);
    for (int i = 0; i < n; i++) begin
      e.done = (i == n - 1);
      e.addr = addr[11:0] + 12'(i);
      e.data = data_q[i];
      exp_q.push_back(e);
      send_byte(data_q[i], pick_gap(max_gap));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    abort    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", in_ready, 1);
    check("clk_en_after_release", ram_clk_en, 1);

    // basic three-byte frame, full throughput
    data_q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(16'h0010, 16'h0003, 0, hdr);
    repeat (3) @(negedge clk);
    check("frame1_latency", done_cyc - hdr, 4 + 3);

    // address wrap
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(16'h0FFE, 16'h0004, 0, hdr);
    repeat (3) @(negedge clk);
    check("wrap_latency", done_cyc - hdr, 4 + 4);

    // length 0 and length 0x2000 both load a full 4096 bytes
    data_q.delete();
    for (int i = 0; i < 4096; i++) data_q.push_back(8'(i) ^ 8'h5A);
    send_frame(16'h0100, 16'h0000, 0, hdr);
    repeat (3) @(negedge clk);
    check("len0_latency", done_cyc - hdr, 4 + 4096);
    data_q.delete();
    for (int i = 0; i < 4096; i++) data_q.push_back(8'(i * 7));
    send_frame(16'hFF80, 16'h2000, 0, hdr);
    repeat (3) @(negedge clk);
    check("len2000_latency", done_cyc - hdr, 4 + 4096);
    check("queue_empty_big", exp_q.size(), 0);

    // rejected header bytes
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    repeat (2) @(negedge clk);
    check("err_count_two", err_count, 2);
    data_q = '{8'h11, 8'h22};
    send_frame(16'h0020, 16'h0002, 1, hdr);
    repeat (3) @(negedge clk);
    check("err_count_after_frame", err_count, 2);
    for (int i = 0; i < 300; i++) send_byte((i % 2 == 1) ? 8'h47 : 8'h00, 0);
    repeat (2) @(negedge clk);
    check("err_count_saturated", err_count, 255);

    // abort on the second data byte
    send_prefix(16'h0200, 16'h0005, 0, hdr);
    e = '{done: 1'b0, addr: 12'h200, data: 8'h10};
    exp_q.push_back(e);
    send_byte(8'h10, 0);
    @(negedge clk);
    in_data  = 8'h20;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort_busy_low", busy, 0);
    check("abort_no_write", ram_wr, 0);
    repeat (3) @(negedge clk);
    check("abort_queue_empty", exp_q.size(), 0);
    data_q = '{8'h77, 8'h88};
    send_frame(16'h0300, 16'h0002, 0, hdr);
    repeat (3) @(negedge clk);

    // reset in the middle of DATA with random gaps
    send_prefix(16'h0400, 16'h000A, 2, hdr);
    for (int i = 0; i < 4; i++) begin
      e = '{done: 1'b0, addr: 12'h400 + 12'(i), data: 8'h30 + 8'(i)};
      exp_q.push_back(e);
      send_byte(8'h30 + 8'(i), pick_gap(2));
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_ram_wr", ram_wr, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_ram_data", ram_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midrst", in_ready, 1);
    data_q = '{8'hDE, 8'hAD, 8'hBE};
    send_frame(16'h0500, 16'h0003, 1, hdr);
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
